// File: rtl/md5_digest_check.sv
// md5_digest_check
// Final MD5 feed-forward, digest formation and target comparison.
// Two enabled register stages: stage 1 adds the initial vector to the
// last hash-stage words, stage 2 byte-swaps them into standard digest
// order and registers the equality against the host target.  The first
// matching candidate index is latched until reset or clear.
// Optional build macro: MD5_MATCH_COUNT_EN adds a saturating 16-bit
// count of every qualifying match on output match_count.
module md5_digest_check #(
   parameter logic [31:0] A0    = 32'h67452301,
   parameter logic [31:0] B0    = 32'hefcdab89,
   parameter logic [31:0] C0    = 32'h98badcfe,
   parameter logic [31:0] D0    = 32'h10325476,
   parameter int          IDX_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             clear,
   input  logic [31:0]      a_in,
   input  logic [31:0]      b_in,
   input  logic [31:0]      c_in,
   input  logic [31:0]      d_in,
   input  logic             valid_in,
   input  logic [127:0]     target,
   output logic [127:0]     digest,
   output logic             digest_valid,
   output logic             match_found,
   output logic [IDX_W-1:0] match_index
`ifdef MD5_MATCH_COUNT_EN
   ,
   output logic [15:0]      match_count
`endif
);

   // Word 0 is a, word 3 is d; digest places word 0 in the top bits.
   logic [31:0]      w_in   [4];
   logic [31:0]      w_iv   [4];
   logic [31:0]      w_sum  [4];
   logic [31:0]      r_sum  [4];
   logic [127:0]     w_swapped;
   logic             w_eq;
   logic             w_match_hit;

   logic [IDX_W-1:0] r_counter;
   logic             r_v1;
   logic [IDX_W-1:0] r_idx1;
   logic [127:0]     r_digest;
   logic             r_digest_valid;
   logic [IDX_W-1:0] r_idx2;
   logic             r_eq2;
   logic             r_match_found;
   logic [IDX_W-1:0] r_match_index;

   assign w_in[0] = a_in;
   assign w_in[1] = b_in;
   assign w_in[2] = c_in;
   assign w_in[3] = d_in;
   assign w_iv[0] = A0;
   assign w_iv[1] = B0;
   assign w_iv[2] = C0;
   assign w_iv[3] = D0;

   // Feed-forward addition (carry out discarded) and byte reversal of
   // each registered sum: the low byte of word a is the first digest byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_word
         assign w_sum[gi] = w_in[gi] + w_iv[gi];
         assign w_swapped[127-32*gi -: 32] = {r_sum[gi][7:0],   r_sum[gi][15:8],
                                              r_sum[gi][23:16], r_sum[gi][31:24]};
      end
   endgenerate

   // The compare uses the same swapped value that stage 2 loads into digest,
   // so eq2 always describes the digest sitting beside it.
   assign w_eq        = (w_swapped == target);
   assign w_match_hit = en && r_digest_valid && r_eq2;

   // Stage 1 data: IV-added words, advanced only with the pipeline.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) r_sum[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < 4; i++) r_sum[i] <= w_sum[i];
      end
   end

   // Candidate counter, stage 1 valid and index tag; clear drops any
   // candidate arriving in the same cycle and restarts numbering at 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_counter <= '0;
         r_v1      <= 1'b0;
         r_idx1    <= '0;
      end else if (clear) begin
         r_counter <= '0;
         r_v1      <= 1'b0;
      end else if (en) begin
         r_v1   <= valid_in;
         r_idx1 <= r_counter;
         if (valid_in) r_counter <= r_counter + IDX_W'(1);
      end
   end

   // Stage 2 data: swapped digest, its index tag and the registered compare.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_digest <= '0;
         r_idx2   <= '0;
         r_eq2    <= 1'b0;
      end else if (en) begin
         r_digest <= w_swapped;
         r_idx2   <= r_idx1;
         r_eq2    <= w_eq;
      end
   end

   // Stage 2 valid; holds while en is low, flushed by clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_digest_valid <= 1'b0;
      end else if (clear) begin
         r_digest_valid <= 1'b0;
      end else if (en) begin
         r_digest_valid <= r_v1;
      end
   end

   // Sticky first-match capture; clear beats a match in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_match_found <= 1'b0;
         r_match_index <= '0;
      end else if (clear) begin
         r_match_found <= 1'b0;
         r_match_index <= '0;
      end else if (w_match_hit && !r_match_found) begin
         r_match_found <= 1'b1;
         r_match_index <= r_idx2;
      end
   end

`ifdef MD5_MATCH_COUNT_EN
   logic [15:0] r_match_count;

   // Saturating count of every qualifying match, not just the first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_match_count <= '0;
      end else if (clear) begin
         r_match_count <= '0;
      end else if (w_match_hit && (r_match_count != 16'hffff)) begin
         r_match_count <= r_match_count + 16'd1;
      end
   end

   assign match_count = r_match_count;
`endif

   assign digest       = r_digest;
   assign digest_valid = r_digest_valid;
   assign match_found  = r_match_found;
   assign match_index  = r_match_index;

endmodule

// File: tb/tb_md5_digest_check.sv
// Testbench for md5_digest_check: directed scenarios plus randomized
// traffic against a candidate-level reference model.  A 32-bit-index and
// a 4-bit-index instance share all inputs.
module tb_md5_digest_check;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         en = 1'b0;
   logic         clear = 1'b0;
   logic [31:0]  a_in = '0, b_in = '0, c_in = '0, d_in = '0;
   logic         valid_in = 1'b0;
   logic [127:0] target = '0;

   logic [127:0] digest, digest4;
   logic         digest_valid, digest_valid4;
   logic         match_found, match_found4;
   logic [31:0]  match_index;
   logic [3:0]   match_index4;
`ifdef MD5_MATCH_COUNT_EN
   logic [15:0]  match_count, match_count4;
`endif

   localparam logic [127:0] ZERO_DIGEST = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] WRAP_DIGEST = 128'h0000000089abcdeffedcba9876543210;

   always #5 clk = ~clk;

   md5_digest_check #(.IDX_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
      .valid_in(valid_in), .target(target),
      .digest(digest), .digest_valid(digest_valid),
      .match_found(match_found), .match_index(match_index)
`ifdef MD5_MATCH_COUNT_EN
      , .match_count(match_count)
`endif
   );

   md5_digest_check #(.IDX_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
      .valid_in(valid_in), .target(target),
      .digest(digest4), .digest_valid(digest_valid4),
      .match_found(match_found4), .match_index(match_index4)
`ifdef MD5_MATCH_COUNT_EN
      , .match_count(match_count4)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // MD5 output: each IV-added word emitted little-endian, a first.
   function automatic logic [127:0] ref_digest(input logic [31:0] a, b, c, d);
      logic [31:0]  w [4];
      logic [127:0] r;
      w[0] = a + 32'h67452301;
      w[1] = b + 32'hefcdab89;
      w[2] = c + 32'h98badcfe;
      w[3] = d + 32'h10325476;
      r = '0;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            r[127-32*k-8*j -: 8] = w[k][8*j +: 8];
      return r;
   endfunction

   // Reference model: each enabled cycle moves a candidate one slot
   // closer to the output; the output slot is judged against target.
   logic         m_mid_v = 0, m_out_v = 0, m_out_eq = 0;
   logic [127:0] m_mid_d = '0, m_out_d = '0;
   logic [31:0]  m_mid_i = '0, m_out_i = '0, m_cnt = '0;
   logic         m_found = 0;
   logic [31:0]  m_index = '0;
   int           m_mcount = 0;

   task automatic model_reset();
      m_mid_v = 0; m_out_v = 0; m_out_eq = 0;
      m_mid_d = '0; m_out_d = '0; m_mid_i = '0; m_out_i = '0; m_cnt = '0;
      m_found = 0; m_index = '0; m_mcount = 0;
   endtask

   task automatic model_edge();
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (en && m_out_v && m_out_eq) begin
         if (!m_found) begin
            m_found = 1;
            m_index = m_out_i;
         end
         if (m_mcount < 65535) m_mcount++;
      end
      if (en) begin
         m_out_v  = m_mid_v;
         m_out_d  = m_mid_d;
         m_out_i  = m_mid_i;
         m_out_eq = (m_mid_d == target);
         m_mid_v  = valid_in;
         m_mid_d  = ref_digest(a_in, b_in, c_in, d_in);
         m_mid_i  = m_cnt;
         if (valid_in) m_cnt = m_cnt + 1;
      end
      if (clear) begin
         m_cnt = '0; m_mid_v = 0; m_out_v = 0;
         m_found = 0; m_index = '0; m_mcount = 0;
      end
   endtask

   // One clock with the given inputs; the model advances at the same edge.
   task automatic step(input logic e, input logic v, input logic c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] cc, input logic [31:0] d);
      en = e; valid_in = v; clear = c;
      a_in = a; b_in = b; c_in = cc; d_in = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cand(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
      step(1, 1, 0, a, b, c, d);
   endtask

   task automatic cand_rand();
      cand($urandom | 32'h1, $urandom, $urandom, $urandom);
   endtask

   task automatic do_clear();
      step(1, 0, 1, 0, 0, 0, 0);
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      check("digest_valid", 128'(digest_valid), 128'(m_out_v));
      check("match_found", 128'(match_found), 128'(m_found));
      check("match_index", 128'(match_index), 128'(m_index));
      check("digest_valid4", 128'(digest_valid4), 128'(m_out_v));
      check("match_found4", 128'(match_found4), 128'(m_found));
      check("match_index4", 128'(match_index4), 128'(m_index[3:0]));
      if (m_out_v) begin
         check("digest", digest, m_out_d);
         check("digest4", digest4, m_out_d);
      end
`ifdef MD5_MATCH_COUNT_EN
      check("match_count", 128'(match_count), 128'(m_mcount));
      check("match_count4", 128'(match_count4), 128'(m_mcount));
`endif
   end

   logic [31:0] key [4];

   initial begin
      // Model pins against hand-computed digests.
      check("model_zero_digest", ref_digest(0, 0, 0, 0), ZERO_DIGEST);
      check("model_wrap_digest", ref_digest(32'h98badcff, 0, 0, 0), WRAP_DIGEST);

      // Reset state.
      #22;
      check("reset_digest", digest, 128'h0);
      check("reset_valid", 128'(digest_valid), 128'h0);
      check("reset_found", 128'(match_found), 128'h0);
      check("reset_index", 128'(match_index), 128'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Zero-state: digest appears after two enabled edges, for one cycle.
      cand(0, 0, 0, 0);
      idle(1);
      check("zero_digest", digest, ZERO_DIGEST);
      check("zero_valid", 128'(digest_valid), 128'h1);
      idle(1);
      check("zero_valid_drop", 128'(digest_valid), 128'h0);

      // Feed-forward carry is discarded.
      cand(32'h98badcff, 0, 0, 0);
      idle(1);
      check("wrap_digest", digest, WRAP_DIGEST);
      idle(2);

      // First match wins: candidates 2 and 4 both match.
      target = ZERO_DIGEST;
      do_clear();
      for (int i = 0; i < 5; i++) begin
         if (i == 2 || i == 4) cand(0, 0, 0, 0);
         else cand_rand();
      end
      idle(4);
      check("first_match_found", 128'(match_found), 128'h1);
      check("first_match_index", 128'(match_index), 128'd2);
`ifdef MD5_MATCH_COUNT_EN
      check("first_match_count", 128'(match_count), 128'd2);
`endif

      // Stall: en low with matching words presented must not count.
      do_clear();
      for (int i = 0; i < 3; i++) cand_rand();
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
      cand(0, 0, 0, 0);
      idle(4);
      check("stall_found", 128'(match_found), 128'h1);
      check("stall_index", 128'(match_index), 128'd3);

      // Clear in the cycle the match would latch.
      do_clear();
      cand(0, 0, 0, 0);
      idle(1);
      step(1, 0, 1, 0, 0, 0, 0);
      check("collide_found", 128'(match_found), 128'h0);
      check("collide_index", 128'(match_index), 128'h0);
      cand(0, 0, 0, 0);
      idle(4);
      check("collide_next_found", 128'(match_found), 128'h1);
      check("collide_next_index", 128'(match_index), 128'h0);

      // Index wrap on the narrow instance: candidate 16 maps to 0.
      do_clear();
      for (int i = 0; i < 17; i++) begin
         if (i == 16) cand(0, 0, 0, 0);
         else cand_rand();
      end
      idle(4);
      check("wrap4_index", 128'(match_index4), 128'h0);
      check("wrap32_index", 128'(match_index), 128'd16);

      // Asynchronous reset between edges, mid-stream.
      do_clear();
      target = ref_digest(1, 2, 3, 4);
      for (int i = 0; i < 3; i++) cand(1, 2, 3, 4);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("areset_digest", digest, 128'h0);
      check("areset_valid", 128'(digest_valid), 128'h0);
      check("areset_found", 128'(match_found), 128'h0);
      check("areset_index", 128'(match_index), 128'h0);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      cand(1, 2, 3, 4);
      idle(4);
      check("areset_next_found", 128'(match_found), 128'h1);
      check("areset_next_index", 128'(match_index), 128'h0);

      // Randomized traffic with occasional clears and target changes.
      for (int k = 0; k < 4; k++) key[k] = $urandom;
      target = ref_digest(key[0], key[1], key[2], key[3]);
      for (int n = 0; n < 600; n++) begin
         logic e, v, c;
         e = ($urandom_range(0, 7) != 0);
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 4) == 0)
            step(e, v, c, key[0], key[1], key[2], key[3]);
         else
            step(e, v, c, $urandom, $urandom, $urandom, $urandom);
         if (n % 150 == 149) begin
            for (int k = 0; k < 4; k++) key[k] = $urandom;
            target = ref_digest(key[0], key[1], key[2], key[3]);
         end
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
